// File: rtl/race_ctrl_pkg.sv
// race_pkg: shared constants and helpers for the race controller.
//   - State encoding (legacy 2-bit values driven onto the state output).
//   - Per-mode value limits, step sizes and defaults.
//   - Auto-return delay in seconds (only used with RACE_CTRL_AUTO_RETURN_EN).
//   - btn_edges_t bundles the one-tick rising-edge strobes of the four buttons.
//   - step_value(): saturating up/down step for the SELECT screen.
package race_pkg;

    localparam logic [1:0] ST_SELECT    = 2'd0;
    localparam logic [1:0] ST_COUNTDOWN = 2'd1;
    localparam logic [1:0] ST_INGAME    = 2'd2;
    localparam logic [1:0] ST_FINISH    = 2'd3;

    // Mode 0: timed race, value in seconds.
    localparam logic [6:0] M0_MIN  = 7'd15;
    localparam logic [6:0] M0_MAX  = 7'd120;
    localparam logic [6:0] M0_STEP = 7'd15;
    localparam logic [6:0] M0_DEF  = 7'd30;

    // Mode 1: word-count race, value is the word target.
    localparam logic [6:0] M1_MIN  = 7'd10;
    localparam logic [6:0] M1_MAX  = 7'd60;
    localparam logic [6:0] M1_STEP = 7'd5;
    localparam logic [6:0] M1_DEF  = 7'd25;

    localparam int AUTO_RETURN_SEC = 10;

    typedef struct packed {
        logic start;
        logic abort;
        logic up;
        logic down;
    } btn_edges_t;

    function automatic logic [6:0] mode_default(input logic m);
        return m ? M1_DEF : M0_DEF;
    endfunction

    // Simultaneous up and down cancel; otherwise step and clamp to the mode's range.
    function automatic logic [6:0] step_value(input logic m, input logic [6:0] v,
                                              input logic up, input logic dn);
        logic [6:0] lo;
        logic [6:0] hi;
        logic [6:0] st;
        logic [7:0] sum;
        logic [6:0] res;
        lo  = m ? M1_MIN  : M0_MIN;
        hi  = m ? M1_MAX  : M0_MAX;
        st  = m ? M1_STEP : M0_STEP;
        sum = {1'b0, v} + {1'b0, st};
        res = v;
        if (up && !dn) begin
            res = (sum > {1'b0, hi}) ? hi : sum[6:0];
        end else if (dn && !up) begin
            res = (v < lo + st) ? lo : v - st;
        end
        return res;
    endfunction

endpackage

// File: rtl/race_ctrl_if.sv
// race_ctrl_if: button/status bundle between the game datapath/UI and race_ctrl.
//   Inputs to the controller : start_btn, abort_btn, up_btn, down_btn, mode_sw, finish
//   Outputs of the controller: state[1:0], mode, value[6:0], cd_sec[1:0], race_done
//   master = driver of the buttons (UI / bench), slave = race_ctrl.
interface race_ctrl_if;

    logic       start_btn;
    logic       abort_btn;
    logic       up_btn;
    logic       down_btn;
    logic       mode_sw;
    logic       finish;

    logic [1:0] state;
    logic       mode;
    logic [6:0] value;
    logic [1:0] cd_sec;
    logic       race_done;

    modport master (
        output start_btn, abort_btn, up_btn, down_btn, mode_sw, finish,
        input  state, mode, value, cd_sec, race_done
    );

    modport slave (
        input  start_btn, abort_btn, up_btn, down_btn, mode_sw, finish,
        output state, mode, value, cd_sec, race_done
    );

endinterface

// File: rtl/race_ctrl_btn_edge.sv
// btn_edge: rising-edge detector for one debounced button level.
//   clk_div : game tick clock
//   rst     : asynchronous active-high reset
//   btn_i   : debounced button level
//   edge_o  : one-tick strobe on a 0->1 transition
module btn_edge (
    input  logic clk_div,
    input  logic rst,
    input  logic btn_i,
    output logic edge_o
);

    logic prev_q;
    logic armed_q;

    // History resets to 0, so armed_q masks the first tick after reset: a
    // button held through reset release must not look like a fresh press.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= btn_i;
            armed_q <= 1'b1;
        end
    end

    assign edge_o = armed_q & btn_i & ~prev_q;

endmodule

// File: rtl/race_ctrl.sv
// race_ctrl: race game flow controller SELECT -> COUNTDOWN -> INGAME -> FINISH.
//   Parameters: TICKS_PER_SEC (clk_div ticks per second), CD_SEC (countdown 1..3 s)
//   clk_div : 100 Hz game tick clock
//   rst     : asynchronous active-high reset
//   bus     : race_ctrl_if.slave (buttons, mode switch, finish in; state,
//             mode, value, cd_sec, race_done out)
//   Optional: RACE_CTRL_AUTO_RETURN_EN adds an idle timeout that returns from
//             FINISH to SELECT after AUTO_RETURN_SEC seconds.
module race_ctrl
    import race_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int CD_SEC        = 3
) (
    input  logic        clk_div,
    input  logic        rst,
    race_ctrl_if.slave  bus
);

    localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

    btn_edges_t edg;

    btn_edge u_start (.clk_div(clk_div), .rst(rst), .btn_i(bus.start_btn), .edge_o(edg.start));
    btn_edge u_abort (.clk_div(clk_div), .rst(rst), .btn_i(bus.abort_btn), .edge_o(edg.abort));
    btn_edge u_up    (.clk_div(clk_div), .rst(rst), .btn_i(bus.up_btn),    .edge_o(edg.up));
    btn_edge u_down  (.clk_div(clk_div), .rst(rst), .btn_i(bus.down_btn),  .edge_o(edg.down));

    logic [1:0]       state_q, state_d;
    logic             mode_q,  mode_d;
    logic [6:0]       value_q, value_d;
    logic [1:0]       cd_q,    cd_d;
    logic [SUB_W-1:0] sub_q,   sub_d;
    logic             done_q,  done_d;

`ifdef RACE_CTRL_AUTO_RETURN_EN
    localparam int IDLE_TICKS = AUTO_RETURN_SEC * TICKS_PER_SEC;
    localparam int IDLE_W     = $clog2(IDLE_TICKS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TICKS - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        value_d = value_q;
        cd_d    = cd_q;
        sub_d   = sub_q;
        done_d  = 1'b0;
`ifdef RACE_CTRL_AUTO_RETURN_EN
        idle_d  = idle_q;
`endif

        // Setup editing is independent of the flow transitions below; a mode
        // change loads the new mode's default and swallows any up/down edge.
        if (state_q == ST_SELECT) begin
            mode_d = bus.mode_sw;
            if (bus.mode_sw != mode_q) begin
                value_d = mode_default(bus.mode_sw);
            end else begin
                value_d = step_value(mode_q, value_q, edg.up, edg.down);
            end
        end

        if (edg.abort) begin
            state_d = ST_SELECT;
            cd_d    = '0;
            sub_d   = '0;
        end else begin
            case (state_q)
                ST_SELECT: begin
                    if (edg.start) begin
                        state_d = ST_COUNTDOWN;
                        cd_d    = 2'(CD_SEC);
                        sub_d   = '0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (cd_q == 2'd1) begin
                            state_d = ST_INGAME;
                            cd_d    = '0;
                        end else begin
                            cd_d = cd_q - 2'd1;
                        end
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                ST_INGAME: begin
                    if (bus.finish) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
`ifdef RACE_CTRL_AUTO_RETURN_EN
                        idle_d  = '0;
`endif
                    end
                end
                ST_FINISH: begin
`ifdef RACE_CTRL_AUTO_RETURN_EN
                    if (edg.start || idle_q == IDLE_LAST) begin
                        state_d = ST_SELECT;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
`else
                    if (edg.start) begin
                        state_d = ST_SELECT;
                    end
`endif
                end
                default: state_d = ST_SELECT;
            endcase
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q <= ST_SELECT;
            mode_q  <= 1'b0;
            value_q <= M0_DEF;
            cd_q    <= '0;
            sub_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            value_q <= value_d;
            cd_q    <= cd_d;
            sub_q   <= sub_d;
            done_q  <= done_d;
        end
    end

`ifdef RACE_CTRL_AUTO_RETURN_EN
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign bus.state     = state_q;
    assign bus.mode      = mode_q;
    assign bus.value     = value_q;
    assign bus.cd_sec    = cd_q;
    assign bus.race_done = done_q;

endmodule

// File: tb/tb_race_ctrl.sv
// tb_race_ctrl: self-checking bench for race_ctrl.
//   A behavioural model (elapsed-tick arithmetic, integer clamping) is compared
//   against the DUT on every falling clock edge; directed scenarios add literal
//   expectations, followed by a randomized phase including mid-run resets.
module tb_race_ctrl;

    localparam int TPS = 100;
    localparam int CDS = 3;

    logic clk_div = 1'b0;
    logic rst     = 1'b1;
    logic chk_en  = 1'b0;

    int checks = 0;
    int errors = 0;

    race_ctrl_if bus ();

    race_ctrl #(
        .TICKS_PER_SEC(TPS),
        .CD_SEC(CDS)
    ) dut (
        .clk_div(clk_div),
        .rst(rst),
        .bus(bus.slave)
    );

    initial forever #5 clk_div = ~clk_div;

    // ---------------- behavioural model ----------------
    int         m_st;
    int         m_val;
    int         m_elapsed;
    int         m_idle;
    logic       m_mode;
    logic       m_done;
    logic [3:0] m_prev;
    logic       m_armed;

    function automatic int lo_of(input logic m);   return m ? 10 : 15;  endfunction
    function automatic int hi_of(input logic m);   return m ? 60 : 120; endfunction
    function automatic int stp_of(input logic m);  return m ? 5  : 15;  endfunction
    function automatic int dflt_of(input logic m); return m ? 25 : 30;  endfunction

    function automatic int m_cd();
        return (m_st == 1) ? CDS - m_elapsed / TPS : 0;
    endfunction

    always @(posedge clk_div or posedge rst) begin : model
        int         n_st, n_val, n_el, n_idle;
        logic       n_mode, n_done;
        logic [3:0] now, e;
        if (rst) begin
            m_st      <= 0;
            m_val     <= 30;
            m_elapsed <= 0;
            m_idle    <= 0;
            m_mode    <= 1'b0;
            m_done    <= 1'b0;
            m_prev    <= '0;
            m_armed   <= 1'b0;
        end else begin
            // e[3]=start, e[2]=abort, e[1]=up, e[0]=down
            now    = {bus.start_btn, bus.abort_btn, bus.up_btn, bus.down_btn};
            e      = m_armed ? (now & ~m_prev) : 4'b0000;
            n_st   = m_st;
            n_val  = m_val;
            n_el   = m_elapsed;
            n_idle = m_idle;
            n_mode = m_mode;
            n_done = 1'b0;
            if (m_st == 0) begin
                if (bus.mode_sw != m_mode) begin
                    n_mode = bus.mode_sw;
                    n_val  = dflt_of(bus.mode_sw);
                end else if (e[1] && !e[0]) begin
                    n_val = (m_val + stp_of(m_mode) > hi_of(m_mode)) ? hi_of(m_mode) : m_val + stp_of(m_mode);
                end else if (e[0] && !e[1]) begin
                    n_val = (m_val - stp_of(m_mode) < lo_of(m_mode)) ? lo_of(m_mode) : m_val - stp_of(m_mode);
                end
            end
            if (e[2]) begin
                n_st = 0;
                n_el = 0;
            end else begin
                case (m_st)
                    0: if (e[3]) begin n_st = 1; n_el = 0; end
                    1: begin
                        n_el = m_elapsed + 1;
                        if (n_el == CDS * TPS) n_st = 2;
                    end
                    2: if (bus.finish) begin n_st = 3; n_done = 1'b1; n_idle = 0; end
                    default: begin
                        if (e[3]) n_st = 0;
`ifdef RACE_CTRL_AUTO_RETURN_EN
                        else begin
                            n_idle = m_idle + 1;
                            if (n_idle == 10 * TPS) n_st = 0;
                        end
`endif
                    end
                endcase
            end
            m_st      <= n_st;
            m_val     <= n_val;
            m_elapsed <= n_el;
            m_idle    <= n_idle;
            m_mode    <= n_mode;
            m_done    <= n_done;
            m_prev    <= now;
            m_armed   <= 1'b1;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_div) begin
        if (chk_en) begin
            cmp("state",     32'(bus.state),     m_st);
            cmp("mode",      32'(bus.mode),      int'(m_mode));
            cmp("value",     32'(bus.value),     m_val);
            cmp("cd_sec",    32'(bus.cd_sec),    m_cd());
            cmp("race_done", 32'(bus.race_done), int'(m_done));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_div);
            #1;
        end
    endtask

    task automatic press_up();
        bus.up_btn = 1'b1; cyc(1);
        bus.up_btn = 1'b0; cyc(1);
    endtask

    task automatic press_down();
        bus.down_btn = 1'b1; cyc(1);
        bus.down_btn = 1'b0; cyc(1);
    endtask

    initial begin
        bus.start_btn = 1'b0;
        bus.abort_btn = 1'b0;
        bus.up_btn    = 1'b0;
        bus.down_btn  = 1'b0;
        bus.mode_sw   = 1'b0;
        bus.finish    = 1'b0;
        rst = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        cyc(1);

        // reset values
        cmp("rst_state", 32'(bus.state), 0);
        cmp("rst_mode",  32'(bus.mode),  0);
        cmp("rst_value", 32'(bus.value), 30);
        cmp("rst_cd",    32'(bus.cd_sec), 0);
        cmp("rst_done",  32'(bus.race_done), 0);
        rst = 1'b0;
        cyc(1);

        // word mode default and saturation at both ends
        bus.mode_sw = 1'b1;
        cyc(1);
        cmp("m1_mode",  32'(bus.mode),  1);
        cmp("m1_value", 32'(bus.value), 25);
        repeat (8) press_up();
        cmp("m1_sat_hi", 32'(bus.value), 60);
        repeat (11) press_down();
        cmp("m1_sat_lo", 32'(bus.value), 10);

        // timed race: countdown timing, editing frozen
        bus.mode_sw = 1'b0;
        cyc(1);
        cmp("m0_value", 32'(bus.value), 30);
        bus.start_btn = 1'b1;
        cyc(1);
        cmp("cd_enter", 32'(bus.state), 1);
        cmp("cd_first", 32'(bus.cd_sec), 3);
        bus.start_btn = 1'b0;
        for (int k = 2; k <= 301; k++) begin
            bus.up_btn = (k == 50);
            cyc(1);
            if (k == 100) cmp("cd_t100", 32'(bus.cd_sec), 3);
            if (k == 101) cmp("cd_t101", 32'(bus.cd_sec), 2);
            if (k == 200) cmp("cd_t200", 32'(bus.cd_sec), 2);
            if (k == 201) cmp("cd_t201", 32'(bus.cd_sec), 1);
            if (k == 300) cmp("cd_t300", 32'(bus.state), 1);
            if (k == 301) cmp("ingame_t301", 32'(bus.state), 2);
        end
        cmp("race_value_frozen", 32'(bus.value), 30);

        // finish and return
        bus.finish = 1'b1;
        cyc(1);
        cmp("fin_state", 32'(bus.state), 3);
        cmp("fin_done",  32'(bus.race_done), 1);
        bus.finish = 1'b0;
        cyc(1);
        cmp("fin_done_pulse", 32'(bus.race_done), 0);
        bus.start_btn = 1'b1;
        cyc(1);
        cmp("ret_state", 32'(bus.state), 0);
        cmp("ret_value", 32'(bus.value), 30);
        bus.start_btn = 1'b0;
        cyc(1);

        // abort beats start in countdown
        bus.start_btn = 1'b1;
        cyc(1);
        bus.start_btn = 1'b0;
        cyc(100);
        cmp("abort_pre_cd", 32'(bus.cd_sec), 2);
        bus.abort_btn = 1'b1;
        bus.start_btn = 1'b1;
        cyc(1);
        cmp("abort_state", 32'(bus.state), 0);
        cmp("abort_cd",    32'(bus.cd_sec), 0);
        cmp("abort_done",  32'(bus.race_done), 0);
        bus.abort_btn = 1'b0;
        bus.start_btn = 1'b0;
        cyc(2);
        cmp("abort_stay", 32'(bus.state), 0);

        // reset mid-race with start held through release
        bus.mode_sw = 1'b1;
        cyc(1);
        bus.start_btn = 1'b1;
        cyc(1);
        bus.start_btn = 1'b0;
        cyc(300);
        cmp("pre_rst_ingame", 32'(bus.state), 2);
        bus.start_btn = 1'b1;
        bus.mode_sw   = 1'b0;
        rst = 1'b1;
        #1;
        cmp("async_rst_state", 32'(bus.state), 0);
        cmp("async_rst_mode",  32'(bus.mode),  0);
        cmp("async_rst_value", 32'(bus.value), 30);
        cyc(1);
        rst = 1'b0;
        cyc(3);
        cmp("held_start_state", 32'(bus.state), 0);
        bus.start_btn = 1'b0;
        cyc(1);

        // FINISH idle behaviour
        bus.start_btn = 1'b1;
        cyc(1);
        bus.start_btn = 1'b0;
        cyc(300);
        bus.finish = 1'b1;
        cyc(1);
        bus.finish = 1'b0;
        cmp("idle_fin", 32'(bus.state), 3);
`ifdef RACE_CTRL_AUTO_RETURN_EN
        cyc(999);
        cmp("idle_last", 32'(bus.state), 3);
        cyc(1);
        cmp("idle_return", 32'(bus.state), 0);
`else
        cyc(2000);
        cmp("idle_stays", 32'(bus.state), 3);
        bus.start_btn = 1'b1;
        cyc(1);
        cmp("idle_leave", 32'(bus.state), 0);
        bus.start_btn = 1'b0;
        cyc(1);
`endif

        // randomized phase
        for (int i = 0; i < 20000; i++) begin
            bus.start_btn = ($urandom_range(0, 7) == 0);
            bus.abort_btn = ($urandom_range(0, 299) == 0);
            bus.up_btn    = ($urandom_range(0, 3) == 0);
            bus.down_btn  = ($urandom_range(0, 3) == 0);
            bus.finish    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 63) == 0) bus.mode_sw = ~bus.mode_sw;
            rst = ($urandom_range(0, 4999) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/race_ctrl.md
RACE_CTRL -- requirements
Module: race_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100: clk_div ticks per second.
REQ-002 Parameter CD_SEC, default 3: countdown length in seconds, range 1..3.
REQ-003 Port rst, input, 1: reset, asynchronous, active-high.
REQ-004 Port clk_div, input, 1: 100 Hz game tick clock; all state SHALL be registered on its rising edge.
REQ-005 Port start_btn, input, 1: debounced level; start race / leave results.
REQ-006 Port abort_btn, input, 1: debounced level; return to SELECT from any state.
REQ-007 Port up_btn / down_btn, input, 1 each: debounced level; step value up/down in SELECT.
REQ-008 Port mode_sw, input, 1: 0 = timed race (seconds), 1 = word-count race.
REQ-009 Port finish, input, 1: datapath race-complete level; sampled only in INGAME.
REQ-010 Port state, output, 2: SELECT=0, COUNTDOWN=1, INGAME=2, FINISH=3.
REQ-011 Port mode, output, 1: mode latched for the current race.
REQ-012 Port value, output, 7: seconds (mode 0) or word target (mode 1).
REQ-013 Port cd_sec, output, 2: seconds remaining in COUNTDOWN; 0 in all other states.
REQ-014 Port race_done, output, 1: single-tick pulse on the INGAME->FINISH transition.

Function
REQ-015 All buttons SHALL be rising-edge detected internally; a held button SHALL act exactly once.
REQ-016 SELECT: mode SHALL follow mode_sw every tick; a change of mode SHALL load that mode's default value (mode 0: 30; mode 1: 25).
REQ-017 SELECT, mode 0: up/down SHALL step value by 15, saturating within 15..120.
REQ-018 SELECT, mode 1: up/down SHALL step value by 5, saturating within 10..60.
REQ-019 Simultaneous up and down edges SHALL leave value unchanged.
REQ-020 Outside SELECT, mode, value and mode_sw/up/down SHALL be frozen/ignored.
REQ-021 start edge in SELECT -> COUNTDOWN next tick; cd_sec=CD_SEC, sub-tick counter=0.
REQ-022 COUNTDOWN: sub-tick counter SHALL count 0..TICKS_PER_SEC-1 and wrap; each wrap decrements cd_sec; the wrap at cd_sec=1 SHALL enter INGAME, so COUNTDOWN lasts exactly CD_SEC*TICKS_PER_SEC ticks.
REQ-023 INGAME: finish=1 -> FINISH next tick, race_done=1 for that one tick.
REQ-024 FINISH: start edge -> SELECT; value and mode SHALL be retained.
REQ-025 abort edge in any state -> SELECT next tick, cd_sec=0, no race_done; abort SHALL win over start and finish in the same tick.
REQ-026 start edges in COUNTDOWN and INGAME SHALL be ignored.

Reset
REQ-027 Reset SHALL force state=SELECT, mode=0, value=30, cd_sec=0, race_done=0, counters and edge-detect history to 0 immediately, including mid-race.
REQ-028 A button held high through reset release SHALL NOT produce an edge.

Configuration
REQ-029 With RACE_CTRL_AUTO_RETURN_EN defined, FINISH SHALL return to SELECT automatically after 10*TICKS_PER_SEC ticks with no start edge; a start edge before that SHALL return immediately.
REQ-030 Without RACE_CTRL_AUTO_RETURN_EN, FINISH SHALL be left only by start or abort, and no idle counter SHALL exist.

Structure
REQ-031 Package race_pkg SHALL hold the state encoding, per-mode min/max/step/default value constants and the auto-return second count.
REQ-032 Rising-edge detection SHALL be one sub-module, btn_edge, instantiated once per button.

Verification
REQ-033 Reset, mode_sw=1 -> mode=1, value=25; 8 up edges -> value=60 (saturated); 11 down edges -> value=10.
REQ-034 Mode 0, value=30, start edge -> COUNTDOWN; cd_sec 3,2,1 each held 100 ticks; INGAME on tick 301; up_btn during race leaves value=30.
REQ-035 INGAME, finish=1 -> FINISH next tick with race_done high exactly one tick; start edge -> SELECT with value=30.
REQ-036 COUNTDOWN cd_sec=2, abort and start in the same tick -> SELECT, cd_sec=0, no race_done.
REQ-037 INGAME, assert rst for 1 tick -> SELECT, mode=0, value=30; start held through release -> stays in SELECT.
REQ-038 With RACE_CTRL_AUTO_RETURN_EN: FINISH idle 1000 ticks -> SELECT; without it: still FINISH after 2000 ticks.
